msu_data_server: RTL and testbench

MSU_DATA_SERVER -- requirements
Module: msu_data_server

---
 rtl/msu_data_server.sv | 135 +++++++++++++
 tb/tb_msu_data_server.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msu_data_server.sv
// MSU data server: byte stream front-end over a 16-bit word backend.
// Prefetches words into a small FIFO and serves bytes at cur_addr.
module msu_data_server #(
    parameter int DEPTH = 4
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic [31:0] msu_data_addr,
    input  logic        msu_data_seek,
    output logic [7:0]  msu_data_in,
    output logic        msu_data_busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FLUSH, FETCH, STREAM} state_t;

    state_t         state, state_nxt;
    logic           seek_q;
    logic           discard;
    logic           busy_nxt;
    logic [31:0]    cur_addr;
    logic [31:0]    fetch_addr;
    logic [31:0]    addr_inc;
    logic [15:0]    fifo [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic [15:0]    head;
    logic           seek_edge, jump, do_seek;
    logic           active, ack, push, adv, pop, issue;

    assign addr_inc  = cur_addr + 32'd1;
    assign seek_edge = msu_data_seek & ~seek_q;
    assign jump      = (state == STREAM)
                     && (msu_data_addr != cur_addr)
                     && (msu_data_addr != addr_inc);
    assign do_seek   = seek_edge | jump;
    assign active    = (state == FETCH) || (state == STREAM);
    assign ack       = mem_req & mem_ack;
    assign push      = ack & ~discard & ~do_seek & active;
    assign adv       = (state == STREAM) & ~msu_data_busy & ~do_seek
                     & (msu_data_addr == addr_inc);
    assign pop       = adv & cur_addr[0];
    assign issue     = active & ~do_seek & ~mem_req & ~discard
                     & (count < CW'(DEPTH));
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign head      = fifo[rd_ptr];

    always_comb begin
        state_nxt = state;
        busy_nxt  = msu_data_busy;
        case (state)
            IDLE: busy_nxt = 1'b0;
            FLUSH: begin
                state_nxt = FETCH;
                busy_nxt  = 1'b1;
            end
            FETCH: begin
                if (count != '0) begin
                    state_nxt = STREAM;
                    busy_nxt  = 1'b0;
                end else begin
                    busy_nxt  = 1'b1;
                end
            end
            // Stay busy through the cycle the refill lands so the
            // registered byte is valid before busy drops.
            STREAM: busy_nxt = (count == '0) || (count_nxt == '0);
            default: state_nxt = IDLE;
        endcase
        if (do_seek) begin
            state_nxt = FLUSH;
            busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            seek_q        <= 1'b0;
            discard       <= 1'b0;
            msu_data_busy <= 1'b0;
            msu_data_in   <= 8'd0;
            mem_req       <= 1'b0;
            mem_addr      <= 32'd0;
            cur_addr      <= 32'd0;
            fetch_addr    <= 32'd0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_nxt;
            seek_q        <= msu_data_seek;
            msu_data_busy <= busy_nxt;
            if (state == IDLE)
                msu_data_in <= 8'd0;
            else
                msu_data_in <= cur_addr[0] ? head[15:8] : head[7:0];
            if (do_seek) begin
                cur_addr   <= msu_data_addr;
                fetch_addr <= {msu_data_addr[31:1], 1'b0};
                discard    <= mem_req & ~mem_ack;
            end else begin
                if (adv)  cur_addr   <= addr_inc;
                if (push) fetch_addr <= fetch_addr + 32'd2;
                if (ack)  discard    <= 1'b0;
            end
            if (ack) begin
                mem_req <= 1'b0;
            end else if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= fetch_addr;
            end
            if (state == FLUSH) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (push) fifo[wr_ptr] <= mem_q;
    end

endmodule

// File: tb/tb_msu_data_server.sv
// Randomized bench for msu_data_server against a flat byte-memory model.
// Expected bytes come straight from an address-hash memory image.
module tb_msu_data_server;

    logic        MCLK = 1'b0;
    logic        RESET_N;
    logic [31:0] msu_data_addr;
    logic        msu_data_seek;
    logic [7:0]  msu_data_in;
    logic        msu_data_busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack_r = 1'b0;
    logic        inj_ack = 1'b0;
    logic        mem_ack;
    logic [15:0] mem_q = 16'd0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          lat_max = 0;
    int          wait_cnt = 0;
    bit          stall = 1'b0;
    logic [31:0] log_q[$];

    assign mem_ack = mem_ack_r | inj_ack;

    msu_data_server #(.DEPTH(4)) dut (
        .MCLK          (MCLK),
        .RESET_N       (RESET_N),
        .msu_data_addr (msu_data_addr),
        .msu_data_seek (msu_data_seek),
        .msu_data_in   (msu_data_in),
        .msu_data_busy (msu_data_busy),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_q         (mem_q)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [15:0] ref_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h100) return 16'hBBAA;
        h = a * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] b);
        logic [15:0] w;
        w = ref_word({b[31:1], 1'b0});
        return b[0] ? w[15:8] : w[7:0];
    endfunction

    // Backend memory: acks after a random latency, one-cycle pulse.
    always @(negedge MCLK) begin
        if (mem_ack_r) begin
            mem_ack_r = 1'b0;
        end else if (mem_req && !stall) begin
            if (wait_cnt == 0) begin
                mem_ack_r = 1'b1;
                mem_q     = ref_word(mem_addr);
                log_q.push_back(mem_addr);
                wait_cnt  = $urandom_range(lat_max);
            end else begin
                wait_cnt--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic seek(input logic [31:0] a);
        @(negedge MCLK);
        msu_data_addr = a;
        msu_data_seek = 1'b1;
        @(negedge MCLK);
        msu_data_seek = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        repeat (2) @(negedge MCLK);
        n = 0;
        while (msu_data_busy && n < 400) begin
            @(negedge MCLK);
            n++;
        end
        check({tag, "_rdy"}, {31'd0, msu_data_busy}, 32'd0);
    endtask

    task automatic advance(input string tag, input logic [31:0] a);
        @(negedge MCLK);
        msu_data_addr = a;
        wait_ready(tag);
        check(tag, {24'd0, msu_data_in}, {24'd0, ref_byte(a)});
    endtask

    task automatic quiesce();
        lat_max = 0;
        wait_cnt = 0;
        stall = 1'b0;
        repeat (12) @(negedge MCLK);
        log_q.delete();
    endtask

    initial begin
        logic [31:0] a;
        int          n;
        bit          found;

        RESET_N = 1'b0;
        msu_data_addr = 32'd0;
        msu_data_seek = 1'b0;
        repeat (3) @(negedge MCLK);
        check("rst_busy", {31'd0, msu_data_busy}, 32'd0);
        check("rst_data", {24'd0, msu_data_in}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        RESET_N = 1'b1;
        repeat (3) @(negedge MCLK);
        check("idle_req", {31'd0, mem_req}, 32'd0);

        // Even seek
        lat_max = 2;
        seek(32'h100);
        @(negedge MCLK);
        check("even_busy", {31'd0, msu_data_busy}, 32'd1);
        wait_ready("even");
        check("even_maddr", log_q[0], 32'h100);
        check("even_b0", {24'd0, msu_data_in}, 32'h0AA);
        advance("even_b1", 32'h101);
        check("even_bb", {24'd0, msu_data_in}, 32'h0BB);
        a = 32'h101;
        for (int i = 0; i < 12; i++) begin
            lat_max = $urandom_range(3);
            a = a + 32'd1;
            advance("even_walk", a);
        end

        // Odd seek
        quiesce();
        seek(32'h201);
        wait_ready("odd");
        check("odd_maddr", log_q[0], 32'h200);
        check("odd_b0", {24'd0, msu_data_in},
              {24'd0, ref_word(32'h200) >> 8});
        advance("odd_b1", 32'h202);
        check("odd_lo", {24'd0, msu_data_in},
              {16'd0, 8'd0, ref_word(32'h202) & 16'h00FF});

        // FIFO full
        quiesce();
        seek(32'h600);
        repeat (20) @(negedge MCLK);
        check("full_nreq", log_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check("full_seq", log_q[i], 32'h600 + 32'(2 * i));
        check("full_req0", {31'd0, mem_req}, 32'd0);
        check("full_b0", {24'd0, msu_data_in}, {24'd0, ref_byte(32'h600)});
        advance("full_b1", 32'h601);
        advance("full_b2", 32'h602);
        repeat (6) @(negedge MCLK);
        check("full_nreq2", log_q.size(), 32'd5);
        check("full_next", log_q[4], 32'h608);

        // Seek while a request is outstanding
        quiesce();
        stall = 1'b1;
        seek(32'h1000);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge MCLK);
            n++;
        end
        check("disc_req", {31'd0, mem_req}, 32'd1);
        check("disc_a1", mem_addr, 32'h1000);
        seek(32'h5000);
        repeat (3) @(negedge MCLK);
        stall = 1'b0;
        wait_ready("disc");
        check("disc_log0", log_q[0], 32'h1000);
        check("disc_log1", log_q[1], 32'h5000);
        check("disc_data", {24'd0, msu_data_in}, {24'd0, ref_byte(32'h5000)});
        advance("disc_b1", 32'h5001);

        // Implicit seek by address jump
        seek(32'h300);
        wait_ready("jmp0");
        quiesce();
        @(negedge MCLK);
        msu_data_addr = 32'h400;
        @(negedge MCLK);
        check("jmp_busy", {31'd0, msu_data_busy}, 32'd1);
        wait_ready("jmp");
        check("jmp_maddr", log_q[0], 32'h400);
        check("jmp_data", {24'd0, msu_data_in}, {24'd0, ref_byte(32'h400)});

        // Drain the FIFO with the backend stalled
        repeat (20) @(negedge MCLK);
        stall = 1'b1;
        a = 32'h400;
        n = 0;
        while (!msu_data_busy && n < 12) begin
            @(negedge MCLK);
            a = a + 32'd1;
            msu_data_addr = a;
            repeat (2) @(negedge MCLK);
            if (!msu_data_busy)
                check("drain", {24'd0, msu_data_in}, {24'd0, ref_byte(a)});
            n++;
        end
        check("drain_addr", a, 32'h408);
        repeat (5) @(negedge MCLK);
        check("drain_hold", {31'd0, msu_data_busy}, 32'd1);
        stall = 1'b0;
        wait_ready("refill");
        check("refill", {24'd0, msu_data_in}, {24'd0, ref_byte(32'h408)});

        // Random seeks and walks, including the 32-bit wrap
        for (int s = 0; s < 7; s++) begin
            lat_max = $urandom_range(4);
            a = (s == 0) ? 32'hFFFF_FFFC : $urandom();
            seek(a);
            wait_ready("rnd");
            check("rnd_seek", {24'd0, msu_data_in}, {24'd0, ref_byte(a)});
            n = (s == 0) ? 8 : int'($urandom_range(12, 4));
            for (int i = 0; i < n; i++) begin
                a = a + 32'd1;
                advance("rnd_walk", a);
            end
        end

        // Reset in the middle of a request
        quiesce();
        stall = 1'b1;
        seek(32'h700);
        n = 0;
        while (!mem_req && n < 50) begin
            @(negedge MCLK);
            n++;
        end
        check("rm_req", {31'd0, mem_req}, 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("rm_busy", {31'd0, msu_data_busy}, 32'd0);
        check("rm_data", {24'd0, msu_data_in}, 32'd0);
        check("rm_mreq", {31'd0, mem_req}, 32'd0);
        check("rm_maddr", mem_addr, 32'd0);
        @(negedge MCLK);
        RESET_N = 1'b1;
        stall = 1'b0;
        inj_ack = 1'b1;
        @(negedge MCLK);
        inj_ack = 1'b0;
        msu_data_addr = 32'h900;
        repeat (5) @(negedge MCLK);
        check("rm_idle_req", {31'd0, mem_req}, 32'd0);
        check("rm_idle_busy", {31'd0, msu_data_busy}, 32'd0);
        check("rm_idle_data", {24'd0, msu_data_in}, 32'd0);
        seek(32'h800);
        wait_ready("rm_seek");
        check("rm_seek", {24'd0, msu_data_in}, {24'd0, ref_byte(32'h800)});
        advance("rm_b1", 32'h801);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
